// File: rtl/word_change_monitor_if.sv
// Status-word monitor bus: watched word, runtime masks and the event record
// handshake between the monitor and the management logic.
interface word_change_monitor_if #(
  parameter int WORD_WIDTH  = 8,
  parameter int COUNT_WIDTH = 8
);
  logic [WORD_WIDTH-1:0]  input_word;
  logic [WORD_WIDTH-1:0]  rise_mask;
  logic [WORD_WIDTH-1:0]  fall_mask;
  logic                   event_ready;
  logic                   output_pulse;
  logic                   event_valid;
  logic [WORD_WIDTH-1:0]  event_word;
  logic [WORD_WIDTH-1:0]  event_rise;
  logic [WORD_WIDTH-1:0]  event_fall;
  logic [COUNT_WIDTH-1:0] event_merged;

  modport slave (
    input  input_word, rise_mask, fall_mask, event_ready,
    output output_pulse, event_valid, event_word, event_rise, event_fall,
           event_merged
  );

  modport master (
    output input_word, rise_mask, fall_mask, event_ready,
    input  output_pulse, event_valid, event_word, event_rise, event_fall,
           event_merged
  );
endinterface

// File: rtl/word_change_monitor.sv
// Debounced, maskable word change monitor: a new value must hold before it is
// accepted; qualified changes pulse and are buffered (merging while pending).
module word_change_monitor #(
  parameter int WORD_WIDTH    = 8,
  parameter int STABLE_CYCLES = 3,
  parameter int COUNT_WIDTH   = 8
) (
  input  logic                clock,
  input  logic                clear,
  word_change_monitor_if.slave bus
);

  localparam int               CNT_W      = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] CNT_ACCEPT = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic {
    ST_PRIME = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_prime;

  logic [WORD_WIDTH-1:0]  r_acc;
  logic [WORD_WIDTH-1:0]  r_cand;
  logic [CNT_W-1:0]       r_cnt;

  logic                   r_pulse;
  logic                   r_valid;
  logic [WORD_WIDTH-1:0]  r_word;
  logic [WORD_WIDTH-1:0]  r_rise;
  logic [WORD_WIDTH-1:0]  r_fall;
  logic [COUNT_WIDTH-1:0] r_merged;

  logic                   w_match;
  logic                   w_accept;
  logic [WORD_WIDTH-1:0]  w_rise;
  logic [WORD_WIDTH-1:0]  w_fall;
  logic                   w_qual;

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  function automatic logic [COUNT_WIDTH-1:0] merged_sat_inc(
    input logic [COUNT_WIDTH-1:0] m
  );
    return (&m) ? m : m + COUNT_WIDTH'(1);
  endfunction

  // Prime sequencing: one cycle after clear captures the live word as baseline.
  always_ff @(posedge clock) begin
    if (clear) begin
      r_state <= ST_PRIME;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_PRIME: w_state_nxt = ST_RUN;
      ST_RUN:   w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_PRIME;
    endcase
  end

  always_comb begin
    w_prime = 1'b0;
    if (r_state == ST_PRIME) begin
      w_prime = 1'b1;
    end
  end

  // Stability filter and per-bit classification at the acceptance edge.
  always_comb begin
    w_match  = (bus.input_word == r_cand);
    w_accept = !w_prime && w_match && (r_cnt == CNT_ACCEPT) && (r_cand != r_acc);
    w_rise   = ~r_acc &  r_cand & bus.rise_mask;
    w_fall   =  r_acc & ~r_cand & bus.fall_mask;
    w_qual   = w_accept && (|(w_rise | w_fall));
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      r_acc  <= '0;
      r_cand <= '0;
      r_cnt  <= '0;
    end else if (w_prime) begin
      r_acc  <= bus.input_word;
      r_cand <= bus.input_word;
      r_cnt  <= CNT_MAX;
    end else begin
      if (!w_match) begin
        r_cand <= bus.input_word;
        r_cnt  <= '0;
      end else begin
        r_cnt  <= cnt_sat_inc(r_cnt);
      end
      if (w_accept) begin
        r_acc <= r_cand;
      end
    end
  end

  // Event record: load when free or being consumed, otherwise merge into it.
  always_ff @(posedge clock) begin
    if (clear) begin
      r_pulse  <= 1'b0;
      r_valid  <= 1'b0;
      r_word   <= '0;
      r_rise   <= '0;
      r_fall   <= '0;
      r_merged <= '0;
    end else begin
      r_pulse <= w_qual;
      if (w_qual && (!r_valid || bus.event_ready)) begin
        r_valid  <= 1'b1;
        r_word   <= r_cand;
        r_rise   <= w_rise;
        r_fall   <= w_fall;
        r_merged <= '0;
      end else if (w_qual) begin
        r_word   <= r_cand;
        r_rise   <= r_rise | w_rise;
        r_fall   <= r_fall | w_fall;
        r_merged <= merged_sat_inc(r_merged);
      end else if (r_valid && bus.event_ready) begin
        r_valid  <= 1'b0;
      end
    end
  end

  assign bus.output_pulse = r_pulse;
  assign bus.event_valid  = r_valid;
  assign bus.event_word   = r_word;
  assign bus.event_rise   = r_rise;
  assign bus.event_fall   = r_fall;
  assign bus.event_merged = r_merged;

endmodule
